// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
// Encodings 25..31 are unassigned and complete as illegal opcodes.
package alu_pkg;

  localparam logic [4:0] ALUOp_NOP   = 5'd0;
  localparam logic [4:0] ALUOp_ADD   = 5'd1;
  localparam logic [4:0] ALUOp_ADDU  = 5'd2;
  localparam logic [4:0] ALUOp_SUB   = 5'd3;
  localparam logic [4:0] ALUOp_SUBU  = 5'd4;
  localparam logic [4:0] ALUOp_AND   = 5'd5;
  localparam logic [4:0] ALUOp_OR    = 5'd6;
  localparam logic [4:0] ALUOp_NOR   = 5'd7;
  localparam logic [4:0] ALUOp_XOR   = 5'd8;
  localparam logic [4:0] ALUOp_SLT   = 5'd9;
  localparam logic [4:0] ALUOp_SLTU  = 5'd10;
  localparam logic [4:0] ALUOp_LTZ   = 5'd11;
  localparam logic [4:0] ALUOp_LEZ   = 5'd12;
  localparam logic [4:0] ALUOp_GTZ   = 5'd13;
  localparam logic [4:0] ALUOp_GEZ   = 5'd14;
  localparam logic [4:0] ALUOp_SEQ   = 5'd15;
  localparam logic [4:0] ALUOp_SNE   = 5'd16;
  localparam logic [4:0] ALUOp_MULT  = 5'd17;
  localparam logic [4:0] ALUOp_MULTU = 5'd18;
  localparam logic [4:0] ALUOp_DIV   = 5'd19;
  localparam logic [4:0] ALUOp_DIVU  = 5'd20;
  localparam logic [4:0] ALUOp_MFHI  = 5'd21;
  localparam logic [4:0] ALUOp_MFLO  = 5'd22;
  localparam logic [4:0] ALUOp_MTHI  = 5'd23;
  localparam logic [4:0] ALUOp_MTLO  = 5'd24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative magnitude multiplier (radix-2 shift-add) and restoring divider.
// The divider half exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_lo;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // {acc_hi, acc_lo} is the product register; the multiplier shifts out of acc_lo.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign prod    = neg_lo ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};

  // The last iteration is combinational so results land in the same edge as done.
  assign done = active && (cnt == CW'(WIDTH - 1));

`ifdef ALU_SEQ_DIV_EN
  logic             mode_div, neg_hi;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_hi, div_lo;

  // acc_hi holds the partial remainder, acc_lo the dividend shifting into quotient.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_hi    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_lo    = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};

  assign step_hi = mode_div ? div_hi : mul_hi;
  assign step_lo = mode_div ? div_lo : mul_lo;
  assign hi      = mode_div ? (neg_hi ? -div_hi : div_hi) : prod[2*WIDTH-1:WIDTH];
  assign lo      = mode_div ? (neg_lo ? -div_lo : div_lo) : prod[WIDTH-1:0];
`else
  assign step_hi = mul_hi;
  assign step_lo = mul_lo;
  assign hi      = prod[2*WIDTH-1:WIDTH];
  assign lo      = prod[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      mode_div <= 1'b0;
      neg_hi   <= 1'b0;
`endif
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= a_mag;
      opnd   <= b_mag;
      neg_lo <= a_neg ^ b_neg;
`ifdef ALU_SEQ_DIV_EN
      mode_div <= is_div;
      neg_hi   <= a_neg;
`endif
    end else if (active) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus iterative MULT/DIV feeding HI/LO.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIV/DIVU are illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             compare,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             err
);

  state_t           state, next_state;
  logic [WIDTH-1:0] c_n, hi_n, lo_n;
  logic             cmp_n, err_n;
  logic             md_start, md_signed, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
`ifdef ALU_SEQ_DIV_EN
  logic             md_div;
`endif

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
`ifdef ALU_SEQ_DIV_EN
    .is_div    (md_div),
`endif
    .is_signed (md_signed),
    .a         (a),
    .b         (b),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo)
  );

  always_comb begin
    next_state = state;
    c_n        = c;
    hi_n       = hi;
    lo_n       = lo;
    cmp_n      = compare;
    err_n      = err;
    md_start   = 1'b0;
    md_signed  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    md_div     = 1'b0;
`endif
    case (state)
      S_MUL, S_DIV: begin
        if (md_done) begin
          next_state = S_DONE;
          hi_n       = md_hi;
          lo_n       = md_lo;
          c_n        = md_lo;
          cmp_n      = 1'b0;
          err_n      = 1'b0;
        end
      end
      default: begin
        // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
        next_state = S_IDLE;
        if (start) begin
          next_state = S_DONE;
          c_n        = '0;
          cmp_n      = 1'b0;
          err_n      = 1'b0;
          case (ctrl)
            ALUOp_NOP:              c_n = b;
            ALUOp_ADD, ALUOp_ADDU:  c_n = a + b;
            ALUOp_SUB, ALUOp_SUBU:  c_n = a - b;
            ALUOp_AND:              c_n = a & b;
            ALUOp_OR:               c_n = a | b;
            ALUOp_NOR:              c_n = ~(a | b);
            ALUOp_XOR:              c_n = a ^ b;
            ALUOp_SLT:  c_n = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUOp_SLTU: c_n = {{(WIDTH-1){1'b0}}, (a < b)};
            ALUOp_LTZ:  cmp_n = a[WIDTH-1];
            ALUOp_LEZ:  cmp_n = a[WIDTH-1] | (a == '0);
            ALUOp_GTZ:  cmp_n = ~a[WIDTH-1] & (a != '0);
            ALUOp_GEZ:  cmp_n = ~a[WIDTH-1];
            ALUOp_SEQ:  cmp_n = (a == b);
            ALUOp_SNE:  cmp_n = (a != b);
            ALUOp_MFHI: c_n = hi;
            ALUOp_MFLO: c_n = lo;
            ALUOp_MTHI: begin
              hi_n = a;
              c_n  = a;
            end
            ALUOp_MTLO: begin
              lo_n = a;
              c_n  = a;
            end
            ALUOp_MULT, ALUOp_MULTU: begin
              next_state = S_MUL;
              md_start   = 1'b1;
              md_signed  = (ctrl == ALUOp_MULT);
            end
`ifdef ALU_SEQ_DIV_EN
            ALUOp_DIV, ALUOp_DIVU: begin
              if (b == '0) begin
                lo_n  = '1;
                hi_n  = a;
                c_n   = '1;
                err_n = 1'b1;
              end else begin
                next_state = S_DIV;
                md_start   = 1'b1;
                md_div     = 1'b1;
                md_signed  = (ctrl == ALUOp_DIV);
              end
            end
`endif
            default: err_n = 1'b1;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      c       <= '0;
      zero    <= 1'b1;
      compare <= 1'b0;
      err     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= next_state;
      c       <= c_n;
      zero    <= (c_n == '0);
      compare <= cmp_n;
      err     <= err_n;
      hi      <= hi_n;
      lo      <= lo_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a 32-bit instance driven from a vector
// table plus hand sequences, and a 16-bit instance for narrow-width cases.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  ctrl;
  logic [31:0] a, b;
  logic        busy, done, zero, compare, err;
  logic [31:0] c, hi, lo;

  logic        s_start;
  logic [4:0]  s_ctrl;
  logic [15:0] s_a, s_b;
  logic        s_busy, s_done, s_zero, s_compare, s_err;
  logic [15:0] s_c, s_hi, s_lo;

  int tests    = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        zero;
    logic        cmp;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .zero(zero), .compare(compare),
    .hi(hi), .lo(lo), .err(err)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .ctrl(s_ctrl), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .c(s_c), .zero(s_zero), .compare(s_compare),
    .hi(s_hi), .lo(s_lo), .err(s_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a one-cycle request and returns #1 after the edge that sampled it.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    ctrl  = op;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus16(input logic [4:0] op, input logic [15:0] va, input logic [15:0] vb);
    s_start = 1'b1;
    s_ctrl  = op;
    s_a     = va;
    s_b     = vb;
    @(posedge clk);
    #1;
    s_start = 1'b0;
  endtask

  // Counts cycles from the start cycle (cycle 1 = first after start) to done.
  task automatic waitDone(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic waitDone16(output int n);
    n = 1;
    while (!s_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic addVec(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vc, input logic vz, input logic vcmp, input logic verr);
    vec_t v;
    v.ctrl = op; v.a = va; v.b = vb; v.c = vc; v.zero = vz; v.cmp = vcmp; v.err = verr;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    bit seen;

    addVec(ALUOp_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0);
    addVec(ALUOp_ADDU, 32'h00000005, 32'h00000007, 32'h0000000C, 0, 0, 0);
    addVec(ALUOp_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0);
    addVec(ALUOp_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0);
    addVec(ALUOp_OR,   32'h00001200, 32'h00000034, 32'h00001234, 0, 0, 0);
    addVec(ALUOp_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0);
    addVec(ALUOp_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 0, 0);
    addVec(ALUOp_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 0, 0, 0);
    addVec(ALUOp_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1, 0, 0);
    addVec(ALUOp_LTZ,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1, 1, 0);
    addVec(ALUOp_LEZ,  32'h00000000, 32'h00000000, 32'h00000000, 1, 1, 0);
    addVec(ALUOp_GTZ,  32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0);
    addVec(ALUOp_GEZ,  32'h80000000, 32'h00000000, 32'h00000000, 1, 0, 0);
    addVec(ALUOp_SEQ,  32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0);
    addVec(ALUOp_SNE,  32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0);
    addVec(ALUOp_NOP,  32'hDEADBEEF, 32'h00001234, 32'h00001234, 0, 0, 0);
    addVec(5'd31,      32'h00000001, 32'h00000002, 32'h00000000, 1, 0, 1);

    rst = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
    s_start = 1'b0; s_ctrl = '0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_c", c, 0);
    checkOutput("reset_zero", zero, 1);
    checkOutput("reset_compare", compare, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_done", i), done, 1);
      checkOutput($sformatf("vec%0d_c", i), c, vecs[i].c);
      checkOutput($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
      checkOutput($sformatf("vec%0d_compare", i), compare, vecs[i].cmp);
      checkOutput($sformatf("vec%0d_err", i), err, vecs[i].err);
    end

    applyStimulus(ALUOp_MTHI, 32'hAAAA0000, 32'h0);
    checkOutput("mthi_c", c, 32'hAAAA0000);
    checkOutput("mthi_hi", hi, 32'hAAAA0000);
    applyStimulus(ALUOp_MTLO, 32'h00005555, 32'h0);
    checkOutput("mtlo_lo", lo, 32'h00005555);
    applyStimulus(ALUOp_MFHI, 32'h0, 32'h0);
    checkOutput("mfhi_c", c, 32'hAAAA0000);
    applyStimulus(ALUOp_MFLO, 32'h0, 32'h0);
    checkOutput("mflo_c", c, 32'h00005555);
    applyStimulus(5'd27, 32'h1, 32'h1);
    checkOutput("undef_err", err, 1);
    checkOutput("undef_hi_kept", hi, 32'hAAAA0000);
    checkOutput("undef_lo_kept", lo, 32'h00005555);

`ifdef ALU_SEQ_DIV_EN
    applyStimulus(ALUOp_DIV, 32'hFFFFFFF9, 32'h2);
    checkOutput("div_busy", busy, 1);
    checkOutput("div_hi_stable", hi, 32'hAAAA0000);
    waitDone(n);
    checkOutput("div_latency", n, 33);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);
    checkOutput("div_c", c, 32'hFFFFFFFD);
    checkOutput("div_err", err, 0);
    applyStimulus(ALUOp_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitDone(n);
    checkOutput("divmin_lo", lo, 32'h80000000);
    checkOutput("divmin_hi", hi, 32'h0);
    checkOutput("divmin_err", err, 0);
    applyStimulus(ALUOp_DIVU, 32'h5, 32'h0);
    checkOutput("div0_done", done, 1);
    checkOutput("div0_lo", lo, 32'hFFFFFFFF);
    checkOutput("div0_hi", hi, 32'h5);
    checkOutput("div0_c", c, 32'hFFFFFFFF);
    checkOutput("div0_err", err, 1);
`else
    applyStimulus(ALUOp_DIV, 32'hFFFFFFF9, 32'h2);
    checkOutput("nodiv_done", done, 1);
    checkOutput("nodiv_err", err, 1);
    checkOutput("nodiv_c", c, 0);
    checkOutput("nodiv_hi_kept", hi, 32'hAAAA0000);
    applyStimulus(ALUOp_DIVU, 32'h5, 32'h0);
    checkOutput("nodiv0_done", done, 1);
    checkOutput("nodiv0_err", err, 1);
    checkOutput("nodiv0_lo_kept", lo, 32'h00005555);
`endif

    applyStimulus(ALUOp_MULT, 32'hFFFFFFFD, 32'h7);
    checkOutput("mult_busy", busy, 1);
    waitDone(n);
    checkOutput("mult_latency", n, 33);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFEB);
    checkOutput("mult_c", c, 32'hFFFFFFEB);
    checkOutput("mult_err", err, 0);

    applyStimulus(ALUOp_ADD, 32'h1, 32'h2);
    checkOutput("b2b_done", done, 1);
    checkOutput("b2b_c", c, 32'h3);
    checkOutput("b2b_hi_kept", hi, 32'hFFFFFFFF);

    applyStimulus(ALUOp_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone(n);
    checkOutput("multu_latency", n, 33);
    checkOutput("multu_hi", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo", lo, 32'h00000001);

    // Requests and operand changes while busy must be ignored.
    applyStimulus(ALUOp_MULTU, 32'h6, 32'h7);
    n = 1;
    while (!done && n < 100) begin
      start = 1'b1; ctrl = ALUOp_ADD; a = 32'd100 + n; b = 32'd200;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    checkOutput("ignore_latency", n, 33);
    checkOutput("ignore_lo", lo, 32'd42);
    checkOutput("ignore_hi", hi, 32'd0);

    // Reset at iteration 10 of a MULTU with start pulsing every cycle.
    applyStimulus(ALUOp_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    seen = 1'b0;
    for (int i = 1; i < 10; i++) begin
      start = 1'b1; ctrl = ALUOp_ADD; a = 32'h1; b = 32'h1;
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    checkOutput("abort_no_done", {63'd0, seen}, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_c", c, 0);
    checkOutput("abort_zero", zero, 1);
    checkOutput("abort_err", err, 0);
    checkOutput("abort_hi", hi, 0);
    checkOutput("abort_lo", lo, 0);
    applyStimulus(ALUOp_ADD, 32'h2, 32'h3);
    checkOutput("after_abort_done", done, 1);
    checkOutput("after_abort_c", c, 32'h5);

    rst = 1'b1; start = 1'b1; ctrl = ALUOp_ADD; a = 32'h7; b = 32'h7;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_prio_done", done, 0);
    checkOutput("rst_prio_c", c, 0);

    applyStimulus16(ALUOp_SLT, 16'h8000, 16'h0001);
    checkOutput("w16_slt_c", s_c, 16'h0001);
    applyStimulus16(ALUOp_GEZ, 16'h0000, 16'h0000);
    checkOutput("w16_gez_compare", s_compare, 1);
    checkOutput("w16_gez_c", s_c, 0);
    applyStimulus16(5'd29, 16'h1, 16'h1);
    checkOutput("w16_undef_err", s_err, 1);
    applyStimulus16(ALUOp_MULTU, 16'hFFFF, 16'hFFFF);
    waitDone16(n);
    checkOutput("w16_multu_latency", n, 17);
    checkOutput("w16_multu_hi", s_hi, 16'hFFFE);
    checkOutput("w16_multu_lo", s_lo, 16'h0001);
`ifdef ALU_SEQ_DIV_EN
    applyStimulus16(ALUOp_DIV, 16'hFFF9, 16'h0002);
    waitDone16(n);
    checkOutput("w16_div_latency", n, 17);
    checkOutput("w16_div_lo", s_lo, 16'hFFFD);
    checkOutput("w16_div_hi", s_hi, 16'hFFFF);
`else
    applyStimulus16(ALUOp_DIV, 16'hFFF9, 16'h0002);
    checkOutput("w16_nodiv_done", s_done, 1);
    checkOutput("w16_nodiv_err", s_err, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64, even).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 ctrl  input  5  operation code from alu_pkg.
REQ-006 a, b  input  WIDTH each  operands, sampled with start.
REQ-007 busy  output  1  multi-cycle operation in progress.
REQ-008 done  output  1  one-cycle pulse: c/zero/compare/err valid.
REQ-009 c  output  WIDTH  registered result, held until next done.
REQ-010 zero  output  1  registered (c==0), updated with c.
REQ-011 compare  output  1  registered branch-compare result.
REQ-012 hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-013 err  output  1  illegal opcode or divide-by-zero, valid with done.

Function
REQ-014 States: IDLE, MUL, DIV, DONE; start with busy=0 ends the current cycle's state decision.
REQ-015 Single-cycle ops (NOP=b, ADD/ADDU, SUB/SUBU, AND, OR, NOR, XOR, SLT, SLTU, compares, MFHI, MFLO, MTHI, MTLO): IDLE->DONE, done high the cycle after start.
REQ-016 Arithmetic modulo 2^WIDTH; ADD/SUB produce no overflow trap; SLT signed, SLTU unsigned, result 1/0 zero-extended.
REQ-017 Compare ops LTZ, LEZ, GTZ, GEZ (signed on a), SEQ, SNE: write compare, force c=0; all non-compare ops force compare=0.
REQ-018 MFHI/MFLO: c=hi/lo; MTHI/MTLO: hi/lo=a, c=a.
REQ-019 MULT/MULTU: IDLE->MUL, radix-2 shift-add over magnitudes, exactly WIDTH iteration cycles, then DONE; {hi,lo}=full 2*WIDTH product; c=lo.
REQ-020 DIV/DIVU: IDLE->DIV, restoring divide over WIDTH cycles, then DONE; lo=quotient (truncated toward zero), hi=remainder (sign of a); c=lo.
REQ-021 Multi-cycle latency: done high exactly WIDTH+1 cycles after the start cycle; busy high from cycle after start through the cycle before done.
REQ-022 Signed MULT/DIV: operate on magnitudes, apply sign in final cycle; DIV of most-negative by -1 gives lo=most-negative, hi=0, err=0.
REQ-023 Divide by zero: detected at start, IDLE->DONE in 1 cycle, lo=all ones, hi=a, c=lo, err=1.
REQ-024 Undefined ctrl: 1-cycle completion, c=0, compare=0, hi/lo unchanged, err=1.
REQ-025 DONE->IDLE unconditionally; start in DONE cycle accepted (back-to-back, no bubble).
REQ-026 start while busy=1 ignored; operands not re-sampled mid-operation.
REQ-027 hi/lo change only at completion of MULT/DIV/MTHI/MTLO/div-by-zero, never mid-iteration.

Reset
REQ-028 rst: state=IDLE; busy, done, compare, err=0; c, hi, lo=0; zero=1.
REQ-029 rst during MUL/DIV aborts the operation; no done pulse, hi/lo cleared.
REQ-030 rst has priority over start in the same cycle.

Configuration
REQ-031 Macro ALU_SEQ_DIV_EN defined: divider datapath and DIV state built as specified.
REQ-032 ALU_SEQ_DIV_EN undefined: no divider logic; DIV/DIVU treated as undefined ctrl (REQ-024); MULT unaffected.

Structure
REQ-033 alu_pkg holds ALUOp_* 5-bit codes (existing set plus MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO) and the state enum typedef.
REQ-034 Iterative mult/div datapath is one sub-module, alu_seq_muldiv, with start/done handshake; alu_seq owns FSM and output registers.

Verification
REQ-035 WIDTH=32: ADD a=32'hFFFFFFFF b=1 -> done next cycle, c=0, zero=1, err=0.
REQ-036 MULT a=-3 b=7 -> done 33 cycles after start, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, c=lo.
REQ-037 DIV a=-7 b=2 -> lo=-3, hi=-1; DIVU b=0 a=5 -> done next cycle, lo=32'hFFFFFFFF, hi=5, err=1.
REQ-038 MULTU in progress, start pulses every cycle and rst at iteration 10 -> no done, all outputs at reset values, next start accepted.
REQ-039 WIDTH=16, SLT a=16'h8000 b=1 -> c=1; GEZ a=0 -> compare=1, c=0; undefined ctrl -> err=1; build without ALU_SEQ_DIV_EN, DIV -> err=1 in 1 cycle.
